noc_router_wh: RTL and testbench

Five-port mesh router, successor to the single-flit crossbar router: wormhole switching with per-packet output locking (a packet is the flits up to and including `tlast`), parametrised input buffering, and round-robin fairness. It sits at every mesh node. Ports connect to the local endpoint (P) and the E/W/N/S neighbours. Routing is dimension-ordered X-then-Y on the head flit's `tuser` coordinates, which is deadlock-free without virtual channels.

---
 rtl/noc_router_wh_pkg.sv | 8 +
 rtl/noc_router_wh_if.sv | 19 +
 rtl/noc_router_wh_arb.sv | 42 ++++
 rtl/noc_router_wh.sv | 124 ++++++++++++
 tb/tb_noc_router_wh.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/noc_router_wh_pkg.sv
// noc_pkg: port enumeration and dimension-ordered route function shared by the router
package noc_pkg;
  localparam int NOC_PORTS = 5;
  typedef enum logic [2:0] {NOC_P, NOC_E, NOC_W, NOC_N, NOC_S} noc_port_e;
  function automatic noc_port_e noc_xy_route(int unsigned dx, int unsigned dy, int unsigned cx, int unsigned cy);
    return dx > cx ? NOC_E : dx < cx ? NOC_W : dy < cy ? NOC_N : dy > cy ? NOC_S : NOC_P;
  endfunction
endpackage

// File: rtl/noc_router_wh_if.sv
// axi4_stream_if: one AXI4-Stream link with master/slave views
interface axi4_stream_if #(
  parameter int DATA_W = 32,
  parameter int USER_W = 4,
  parameter int ID_W   = 2,
  parameter int DEST_W = 2
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tstrb;
  logic [DATA_W/8-1:0]   tkeep;
  logic [USER_W-1:0]     tuser;
  logic [ID_W-1:0]       tid;
  logic [DEST_W-1:0]     tdest;
  logic                  tlast;
  modport Master (output tvalid, tdata, tstrb, tkeep, tuser, tid, tdest, tlast, input tready);
  modport Slave  (input tvalid, tdata, tstrb, tkeep, tuser, tid, tdest, tlast, output tready);
endinterface

// File: rtl/noc_router_wh_arb.sv
// noc_wh_arb: round-robin arbiter for one output, locked to the winner until its tlast flit moves
module noc_wh_arb
  import noc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NOC_PORTS-1:0] req_i,
  input  logic [NOC_PORTS-1:0] last_i,
  input  logic                 adv_i,
  output logic [NOC_PORTS-1:0] gnt_o
);
  logic                 lock_q, lock_d;
  logic [2:0]           own_q, own_d, ptr_q, ptr_d, off, pick, sel;
  logic [3:0]           sum;
  logic [NOC_PORTS-1:0] rot;
  logic                 fire;
  always_comb begin
    rot = NOC_PORTS'({req_i, req_i} >> ptr_q);
    off = '0;
    for (int k = NOC_PORTS - 1; k >= 0; k--) off = rot[k] ? 3'(k) : off;
    sum = 4'(ptr_q) + 4'(off);
    pick = sum >= 4'(NOC_PORTS) ? 3'(sum - 4'(NOC_PORTS)) : 3'(sum);
    sel = lock_q ? own_q : pick;
    gnt_o = '0;
    gnt_o[sel] = lock_q ? req_i[own_q] : |req_i;
    fire = |gnt_o && adv_i;
    lock_d = fire ? !last_i[sel] : lock_q;
    own_d = fire ? sel : own_q;
    ptr_d = (fire && !lock_q) ? (pick == 3'(NOC_PORTS - 1) ? '0 : pick + 3'd1) : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= 1'b0;
      own_q  <= '0;
      ptr_q  <= '0;
    end else begin
      lock_q <= lock_d;
      own_q  <= own_d;
      ptr_q  <= ptr_d;
    end
  end
endmodule

// File: rtl/noc_router_wh.sv
// noc_router_wh: five-port wormhole mesh router with XY routing, input FIFOs and output slices
module noc_router_wh
  import noc_pkg::*;
#(
  parameter int DX_W       = 2,
  parameter int DY_W       = 2,
  parameter int CUR_X      = 0,
  parameter int CUR_Y      = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 32,
  parameter int USER_W     = 4,
  parameter int ID_W       = 2,
  parameter int DEST_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axi4_stream_if.Slave         noc_req_i [NOC_PORTS-1:0],
  axi4_stream_if.Master        noc_req_o [NOC_PORTS-1:0],
  output logic [NOC_PORTS-1:0] err_uturn_o
);
  localparam int S_W    = DATA_W / 8;
  localparam int FLIT_W = DATA_W + 2 * S_W + USER_W + ID_W + DEST_W + 1;
  localparam int U_LSB  = 1 + DEST_W + ID_W;
  localparam int AW     = $clog2(FIFO_DEPTH);

  logic [FLIT_W-1:0]    head [NOC_PORTS];
  noc_port_e            route [NOC_PORTS];
  logic [NOC_PORTS-1:0] gnt [NOC_PORTS];
  logic [NOC_PORTS-1:0] nempty, last, pop, adv;

  // each input heads toward exactly one output, so OR-ing grants gives its pop
  always_comb begin
    pop = '0;
    for (int o = 0; o < NOC_PORTS; o++) pop = pop | (gnt[o] & {NOC_PORTS{adv[o]}});
  end

  for (genvar i = 0; i < NOC_PORTS; i++) begin : g_in
    logic [FLIT_W-1:0] mem_q [FIFO_DEPTH];
    logic [FLIT_W-1:0] flit_in;
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              full_q, full_d, head_q, head_d, err_q, err_d, push;
    noc_port_e         route_q, route_d, hroute;
    assign flit_in = {noc_req_i[i].tdata, noc_req_i[i].tstrb, noc_req_i[i].tkeep, noc_req_i[i].tuser,
                      noc_req_i[i].tid, noc_req_i[i].tdest, noc_req_i[i].tlast};
    assign noc_req_i[i].tready = !full_q;
    assign push       = noc_req_i[i].tvalid && !full_q;
    assign head[i]    = mem_q[rd_q];
    assign last[i]    = mem_q[rd_q][0];
    assign nempty[i]  = cnt_q != '0;
    assign hroute     = noc_xy_route(32'(mem_q[rd_q][U_LSB +: DX_W]), 32'(mem_q[rd_q][U_LSB + DX_W +: DY_W]),
                                     CUR_X, CUR_Y);
    // body flits follow the route latched from their packet's head
    assign route[i]   = head_q ? hroute : route_q;
    assign err_uturn_o[i] = err_q;
    always_comb begin
      wr_d    = push ? wr_q + 1'b1 : wr_q;
      rd_d    = pop[i] ? rd_q + 1'b1 : rd_q;
      cnt_d   = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop[i]);
      full_d  = cnt_d == (AW + 1)'(FIFO_DEPTH);
      head_d  = pop[i] ? last[i] : head_q;
      route_d = (pop[i] && head_q) ? hroute : route_q;
      err_d   = err_q || (pop[i] && head_q && hroute == noc_port_e'(i));
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_q    <= '0;
        rd_q    <= '0;
        cnt_q   <= '0;
        full_q  <= 1'b0;
        head_q  <= 1'b1;
        route_q <= NOC_P;
        err_q   <= 1'b0;
      end else begin
        wr_q    <= wr_d;
        rd_q    <= rd_d;
        cnt_q   <= cnt_d;
        full_q  <= full_d;
        head_q  <= head_d;
        route_q <= route_d;
        err_q   <= err_d;
      end
    end
    always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= flit_in;
    end
  end

  for (genvar o = 0; o < NOC_PORTS; o++) begin : g_out
    logic [NOC_PORTS-1:0] req;
    logic [FLIT_W-1:0]    dat_q, dat_d;
    logic                 vld_q, vld_d;
    always_comb begin
      req = '0;
      for (int k = 0; k < NOC_PORTS; k++) req[k] = nempty[k] && route[k] == noc_port_e'(o);
    end
    noc_wh_arb u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req_i  (req),
      .last_i (last),
      .adv_i  (adv[o]),
      .gnt_o  (gnt[o])
    );
    assign adv[o] = !vld_q || noc_req_o[o].tready;
    always_comb begin
      dat_d = dat_q;
      for (int k = 0; k < NOC_PORTS; k++) dat_d = (gnt[o][k] && adv[o]) ? head[k] : dat_d;
      vld_d = (|gnt[o] && adv[o]) || (vld_q && !noc_req_o[o].tready);
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        dat_q <= '0;
      end else begin
        vld_q <= vld_d;
        dat_q <= dat_d;
      end
    end
    assign noc_req_o[o].tvalid = vld_q;
    assign {noc_req_o[o].tdata, noc_req_o[o].tstrb, noc_req_o[o].tkeep, noc_req_o[o].tuser,
            noc_req_o[o].tid, noc_req_o[o].tdest, noc_req_o[o].tlast} = dat_q;
  end
endmodule

// File: tb/tb_noc_router_wh.sv
// tb_noc_router_wh: directed scoreboard bench for the wormhole router at node (1,1)
module tb_noc_router_wh;
  localparam int DW = 32, UW = 6, IW = 2, DSW = 2, DEPTH = 4;
  typedef struct packed {
    logic [DW-1:0]   data;
    logic [DW/8-1:0] strb;
    logic [DW/8-1:0] keep;
    logic [UW-1:0]   user;
    logic [IW-1:0]   id;
    logic [DSW-1:0]  dest;
    logic            last;
  } flit_t;
  typedef struct {
    flit_t f;
    bit    lat;
    int    src;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] err, ovld, irdy;
  logic [4:0] ordy = 5'h1f;
  int         cyc = 0, n_cmp = 0, n_err = 0;
  int         last_acc [5];
  int         acc_cnt [5];
  flit_t      src_q [5][$];
  exp_t       exp_q [5][$];

  axi4_stream_if #(.DATA_W(DW), .USER_W(UW), .ID_W(IW), .DEST_W(DSW)) in_if [4:0] ();
  axi4_stream_if #(.DATA_W(DW), .USER_W(UW), .ID_W(IW), .DEST_W(DSW)) out_if [4:0] ();

  noc_router_wh #(
    .DX_W(2), .DY_W(2), .CUR_X(1), .CUR_Y(1), .FIFO_DEPTH(DEPTH),
    .DATA_W(DW), .USER_W(UW), .ID_W(IW), .DEST_W(DSW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .noc_req_i   (in_if),
    .noc_req_o   (out_if),
    .err_uturn_o (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  for (genvar p = 0; p < 5; p++) begin : g_tb
    bit    acc;
    flit_t got;
    assign ovld[p] = out_if[p].tvalid;
    assign irdy[p] = in_if[p].tready;
    assign out_if[p].tready = ordy[p];
    initial begin
      in_if[p].tvalid = 1'b0;
      in_if[p].tdata = '0; in_if[p].tstrb = '0; in_if[p].tkeep = '0; in_if[p].tuser = '0;
      in_if[p].tid = '0; in_if[p].tdest = '0; in_if[p].tlast = 1'b0;
      forever begin
        @(negedge clk);
        acc = in_if[p].tvalid && in_if[p].tready && rst_n;
        if (acc) begin
          last_acc[p] = cyc;
          acc_cnt[p]++;
        end
        @(posedge clk);
        #1;
        if (acc) void'(src_q[p].pop_front());
        if (src_q[p].size() > 0) begin
          in_if[p].tdata = src_q[p][0].data;
          in_if[p].tstrb = src_q[p][0].strb;
          in_if[p].tkeep = src_q[p][0].keep;
          in_if[p].tuser = src_q[p][0].user;
          in_if[p].tid   = src_q[p][0].id;
          in_if[p].tdest = src_q[p][0].dest;
          in_if[p].tlast = src_q[p][0].last;
          in_if[p].tvalid = 1'b1;
        end else in_if[p].tvalid = 1'b0;
      end
    end
    always @(negedge clk) begin
      if (rst_n && out_if[p].tvalid && ordy[p]) begin
        got = {out_if[p].tdata, out_if[p].tstrb, out_if[p].tkeep, out_if[p].tuser,
               out_if[p].tid, out_if[p].tdest, out_if[p].tlast};
        n_cmp++;
        assert (exp_q[p].size() > 0) else begin
          n_err++;
          $error("FAIL out%0d_extra: observed flit %0h expected none", p, got);
        end
        if (exp_q[p].size() > 0) begin
          chk($sformatf("out%0d_flit", p), 64'(got), 64'(exp_q[p][0].f));
          if (exp_q[p][0].lat) chk($sformatf("out%0d_latency", p), 64'(cyc - last_acc[exp_q[p][0].src]), 64'd2);
          void'(exp_q[p].pop_front());
        end
      end
    end
  end

  // body flits carry coordinates that differ from the head's to exercise the latched route
  task automatic send(int src, int dst, int x, int y, int n, bit lat, bit close = 1'b1);
    flit_t f;
    exp_t  e;
    for (int k = 0; k < n; k++) begin
      f.data = $urandom;
      f.strb = 4'($urandom);
      f.keep = 4'($urandom);
      f.user = {2'($urandom), (k == 0) ? 2'(y) : 2'(y ^ 3), (k == 0) ? 2'(x) : 2'(x ^ 3)};
      f.id   = 2'($urandom);
      f.dest = 2'($urandom);
      f.last = close && (k == n - 1);
      src_q[src].push_back(f);
      e.f = f; e.lat = lat; e.src = src;
      exp_q[dst].push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    int s;
    do begin
      @(posedge clk);
      s = 0;
      for (int p = 0; p < 5; p++) s += exp_q[p].size() + src_q[p].size();
      n++;
    end while (s != 0 && n < 300);
    chk("drain", 64'(s), 64'd0);
    repeat (2) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    chk("rst_tvalid", 64'(ovld), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tready", 64'(irdy), 64'h1f);
    // single-flit packets from P to each direction
    send(0, 1, 3, 1, 1, 1'b1); wait_drain();
    send(0, 3, 1, 0, 1, 1'b1); wait_drain();
    send(0, 4, 1, 3, 1, 1'b1); wait_drain();
    send(0, 2, 0, 2, 1, 1'b1); wait_drain();
    send(0, 0, 1, 1, 1, 1'b1); wait_drain();
    chk("err_p_local", 64'(err), 64'h01);
    // multi-flit packet whose bodies carry other coordinates stays on E
    send(0, 1, 3, 1, 3, 1'b0); wait_drain();
    // backpressure on E
    begin
      int base;
      base = acc_cnt[0];
      ordy[1] = 1'b0;
      send(0, 1, 3, 1, 8, 1'b0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("bp_accepted", 64'(acc_cnt[0] - base), 64'(DEPTH + 1));
      chk("bp_tready", 64'(irdy[0]), 64'h0);
      ordy[1] = 1'b1;
      wait_drain();
    end
    // wormhole lock and round-robin on output P
    do_reset();
    send(1, 0, 1, 1, 4, 1'b0);
    send(2, 0, 1, 1, 4, 1'b0);
    wait_drain();
    send(1, 0, 1, 1, 1, 1'b0);
    wait_drain();
    send(2, 0, 1, 1, 4, 1'b0);
    send(1, 0, 1, 1, 4, 1'b0);
    wait_drain();
    chk("err_after_wormhole", 64'(err), 64'h00);
    // U-turn on E
    send(1, 1, 2, 1, 1, 1'b1); wait_drain();
    chk("err_uturn_e", 64'(err), 64'h02);
    send(1, 0, 1, 1, 2, 1'b0); wait_drain();
    chk("err_uturn_sticky", 64'(err), 64'h02);
    // reset in the middle of a packet
    ordy[1] = 1'b0;
    send(0, 1, 3, 1, 3, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_vld", 64'(ovld[1]), 64'h1);
    do_reset();
    for (int p = 0; p < 5; p++) exp_q[p].delete();
    @(negedge clk);
    chk("mid_rst_tvalid", 64'(ovld), 64'h0);
    chk("mid_rst_tready", 64'(irdy), 64'h1f);
    chk("mid_rst_err", 64'(err), 64'h0);
    ordy[1] = 1'b1;
    @(posedge clk);
    send(0, 4, 1, 3, 1, 1'b1);
    wait_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
